// File: rtl/cnt_ctrl_pkg.sv
// Shared types and reset values for the counter command sequencer.
package cnt_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MOVE_FWD,
        MOVE_BACK,
        DONE,
        ERR
    } state_t;

    typedef enum logic {
        GOTO   = 1'b0,
        BOUNCE = 1'b1
    } mode_t;

    localparam state_t ST_RST    = IDLE;
    localparam logic   UP_DN_RST = 1'b0;

endpackage

// File: rtl/cnt_stall_mon.sv
// Flags a counter that stays put while it is being enabled.
// A cycle counts as stalled only if en was also high the cycle before, since the counter is registered.
module cnt_stall_mon #(
    parameter int N         = 8,
    parameter int STALL_LIM = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_arm,
    input  logic [N-1:0] i_count,
    output logic         o_stall
);

    localparam int               CNT_W  = $clog2(STALL_LIM + 1);
    localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(STALL_LIM - 1);

    logic [N-1:0]     r_prev;
    logic             r_arm_q;
    logic [CNT_W-1:0] r_cnt;
    logic             w_stalled;

    assign w_stalled = i_arm && r_arm_q && (i_count == r_prev);
    assign o_stall   = w_stalled && (r_cnt == LIM_M1);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev  <= '0;
            r_arm_q <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_prev  <= i_count;
            r_arm_q <= i_arm;
            if (!w_stalled)
                r_cnt <= '0;
            else if (r_cnt != LIM_M1)
                r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// Command sequencer steering an up/down counter to a target (GOTO) or back and forth (BOUNCE).
// en/up_dn are gated by a live compare against count so the counter never overshoots.
module cnt_seq_ctrl
    import cnt_ctrl_pkg::*;
#(
    parameter int N         = 8,
    parameter int REPS_W    = 4,
    parameter int STALL_LIM = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic              i_cmd_mode,
    input  logic [N-1:0]      i_cmd_target,
    input  logic [REPS_W-1:0] i_cmd_reps,
    input  logic              i_abort,
    input  logic [N-1:0]      i_count,
    output logic              o_en,
    output logic              o_up_dn,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    state_t            r_state;
    state_t            w_next_state;
    logic [N-1:0]      r_target;
    logic [N-1:0]      r_start;
    mode_t             r_mode;
    logic [REPS_W-1:0] r_reps;
    logic              r_dir;
    logic              r_up_dn;

    logic              w_hs;
    logic              w_en;
    logic              w_up_dn;
    logic              w_stall;
    logic              w_reps_dec;

    assign w_hs = i_cmd_valid && o_cmd_ready;

    // Kept outside the FSM process so the stall path does not form a combinational loop through it.
    assign w_en = (r_state == MOVE_FWD)  ? (i_count != r_target) :
                  (r_state == MOVE_BACK) ? (i_count != r_start)  : 1'b0;

    cnt_stall_mon #(
        .N         (N),
        .STALL_LIM (STALL_LIM)
    ) u_stall_mon (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_arm   (w_en),
        .i_count (i_count),
        .o_stall (w_stall)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= ST_RST;
            r_target <= '0;
            r_start  <= '0;
            r_mode   <= GOTO;
            r_reps   <= '0;
            r_dir    <= 1'b0;
            r_up_dn  <= UP_DN_RST;
        end else begin
            r_state <= w_next_state;
            r_up_dn <= w_up_dn;
            if (w_hs) begin
                r_target <= i_cmd_target;
                r_start  <= i_count;
                r_mode   <= mode_t'(i_cmd_mode);
                r_reps   <= i_cmd_reps;
                r_dir    <= (i_cmd_target > i_count);
            end else if (w_reps_dec) begin
                r_reps <= r_reps - REPS_W'(1);
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_up_dn      = r_up_dn;
        w_reps_dec   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hs)
                    w_next_state = (i_count == i_cmd_target) ? DONE : MOVE_FWD;
            end
            MOVE_FWD: begin
                w_up_dn = r_dir;
                if (i_abort)
                    w_next_state = IDLE;
                else if (w_stall)
                    w_next_state = ERR;
                else if (!w_en)
                    w_next_state = (r_mode == GOTO || r_reps == '0) ? DONE : MOVE_BACK;
            end
            MOVE_BACK: begin
                w_up_dn = ~r_dir;
                if (i_abort)
                    w_next_state = IDLE;
                else if (w_stall)
                    w_next_state = ERR;
                else if (!w_en) begin
                    w_reps_dec   = 1'b1;
                    w_next_state = (r_reps == REPS_W'(1)) ? DONE : MOVE_FWD;
                end
            end
            DONE:    w_next_state = IDLE;
            ERR: begin
                if (i_abort)
                    w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    assign o_en        = w_en;
    assign o_up_dn     = w_up_dn;
    assign o_busy      = (r_state == MOVE_FWD) || (r_state == MOVE_BACK);
    assign o_done      = (r_state == DONE) && !i_abort;
    assign o_err       = (r_state == ERR);
    assign o_cmd_ready = (r_state == IDLE) && !i_rst;

endmodule
